alu_3bit_arbiter: RTL and testbench

Two-requester arbiter and sequencer that shares a single `ALU_3bit` instance. It accepts operations from two independent valid/ready request ports and grants them round-robin. It drives the shared ALU from registered operands and returns result plus flags on a per-requester response port. It sits between the ALU and any two clients, such as a switch-input front end and a test/sequencer engine.

---
 rtl/alu_3bit_arbiter.sv | 179 +++++++++++++++++
 tb/tb_alu_3bit_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_3bit_arbiter.sv
// alu_3bit_arbiter
// Shares one external 3-bit ALU between two requesters. Requests are granted
// round-robin in IDLE, operands are registered and presented to the ALU for one
// EXEC cycle, and the ALU result plus flags are captured into the owning
// requester's response registers, which are held until consumed (RESP).
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   reqN_valid/ready               request handshake (ready is combinational)
//   reqN_a, reqN_b, reqN_op        request payload
//   rspN_valid/ready               response handshake
//   rspN_result, rspN_flags        captured result and
//                                  {greater_than, less_than, equal, zero, carry_out}
//   alu_a, alu_b, alu_sel          registered operands to the shared ALU
//   alu_result, alu_*              results returned by the shared ALU
module alu_3bit_arbiter #(
    parameter bit RR_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [2:0] req0_a,
    input  logic [2:0] req0_b,
    input  logic [2:0] req0_op,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [2:0] req1_a,
    input  logic [2:0] req1_b,
    input  logic [2:0] req1_op,
    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    output logic [2:0] rsp0_result,
    output logic [4:0] rsp0_flags,
    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output logic [2:0] rsp1_result,
    output logic [4:0] rsp1_flags,
    output logic [2:0] alu_a,
    output logic [2:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [2:0] alu_result,
    input  logic       alu_carry_out,
    input  logic       alu_zero,
    input  logic       alu_equal,
    input  logic       alu_less_than,
    input  logic       alu_greater_than
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t     state_r;
    logic       ptr_r;
    logic       owner_r;
    logic [2:0] opa_r;
    logic [2:0] opb_r;
    logic [2:0] opsel_r;
    logic       rsp0_valid_r;
    logic       rsp1_valid_r;
    logic [2:0] rsp0_result_r;
    logic [2:0] rsp1_result_r;
    logic [4:0] rsp0_flags_r;
    logic [4:0] rsp1_flags_r;

    logic       grant_valid_s;
    logic       grant_idx_s;
    logic       rsp_hs_s;
    logic [4:0] alu_flags_s;

    assign alu_flags_s = {alu_greater_than, alu_less_than, alu_equal, alu_zero, alu_carry_out};

    // Grant selection: only in IDLE; the pointer breaks ties when both request.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = 1'b0;
        if (state_r == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant_valid_s = 1'b1;
                grant_idx_s   = ptr_r;
            end else if (req0_valid) begin
                grant_valid_s = 1'b1;
                grant_idx_s   = 1'b0;
            end else if (req1_valid) begin
                grant_valid_s = 1'b1;
                grant_idx_s   = 1'b1;
            end else begin
                grant_valid_s = 1'b0;
                grant_idx_s   = 1'b0;
            end
        end else begin
            grant_valid_s = 1'b0;
            grant_idx_s   = 1'b0;
        end
    end

    // Response handshake on the owner's port; a ready on the other port is ignored.
    always_comb begin
        rsp_hs_s = 1'b0;
        if (owner_r) begin
            rsp_hs_s = rsp1_valid_r && rsp1_ready;
        end else begin
            rsp_hs_s = rsp0_valid_r && rsp0_ready;
        end
    end

    assign req0_ready  = grant_valid_s & ~grant_idx_s;
    assign req1_ready  = grant_valid_s & grant_idx_s;
    assign alu_a       = opa_r;
    assign alu_b       = opb_r;
    assign alu_sel     = opsel_r;
    assign rsp0_valid  = rsp0_valid_r;
    assign rsp1_valid  = rsp1_valid_r;
    assign rsp0_result = rsp0_result_r;
    assign rsp1_result = rsp1_result_r;
    assign rsp0_flags  = rsp0_flags_r;
    assign rsp1_flags  = rsp1_flags_r;

    // Transaction sequencer: accept, execute for one cycle, hold response until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            ptr_r         <= RR_INIT;
            owner_r       <= 1'b0;
            opa_r         <= 3'd0;
            opb_r         <= 3'd0;
            opsel_r       <= 3'd0;
            rsp0_valid_r  <= 1'b0;
            rsp1_valid_r  <= 1'b0;
            rsp0_result_r <= 3'd0;
            rsp1_result_r <= 3'd0;
            rsp0_flags_r  <= 5'd0;
            rsp1_flags_r  <= 5'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_valid_s) begin
                        owner_r <= grant_idx_s;
                        opa_r   <= grant_idx_s ? req1_a  : req0_a;
                        opb_r   <= grant_idx_s ? req1_b  : req0_b;
                        opsel_r <= grant_idx_s ? req1_op : req0_op;
                        state_r <= EXEC;
                    end
                end
                EXEC: begin
                    // Only the owner's response registers are written.
                    if (owner_r) begin
                        rsp1_result_r <= alu_result;
                        rsp1_flags_r  <= alu_flags_s;
                        rsp1_valid_r  <= 1'b1;
                    end else begin
                        rsp0_result_r <= alu_result;
                        rsp0_flags_r  <= alu_flags_s;
                        rsp0_valid_r  <= 1'b1;
                    end
                    state_r <= RESP;
                end
                RESP: begin
                    if (rsp_hs_s) begin
                        if (owner_r) begin
                            rsp1_valid_r <= 1'b0;
                        end else begin
                            rsp0_valid_r <= 1'b0;
                        end
                        ptr_r   <= ~owner_r;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_3bit_arbiter.sv
module tb_alu_3bit_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       vld [2];
    logic [2:0] pa [2];
    logic [2:0] pb [2];
    logic [2:0] po [2];
    logic       rrdy [2];
    logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [2:0] rsp0_result, rsp1_result, alu_a, alu_b, alu_sel, alu_result;
    logic [4:0] rsp0_flags, rsp1_flags;
    logic       alu_carry_out, alu_zero, alu_equal, alu_less_than, alu_greater_than;

    logic       o_vld [2];
    logic [2:0] o_res [2];
    logic [4:0] o_flg [2];
    logic [28:0] all_outs;

    int n_chk = 0;
    int n_fail = 0;

    // Reference state kept by the bench
    logic       exp_ptr;
    logic [2:0] last_a, last_b, last_sel;
    logic [2:0] exp_res [2];
    logic [4:0] exp_flg [2];

    always #5 clk = ~clk;

    // Behavioural ALU: returns {result[2:0], gt, lt, eq, zero, carry}
    function automatic logic [7:0] alu_model(input logic [2:0] a, input logic [2:0] b, input logic [2:0] sel);
        logic [3:0] w;
        logic       c;
        c = 1'b0;
        case (sel)
            3'd0: begin w = {1'b0, a} + {1'b0, b}; c = w[3]; end
            3'd1: begin w = {1'b0, a} - {1'b0, b}; c = w[3]; end
            3'd2: w = {1'b0, a & b};
            3'd3: w = {1'b0, a | b};
            3'd4: w = {1'b0, a ^ b};
            3'd5: w = {1'b0, ~a};
            3'd6: begin w = {a, 1'b0}; c = w[3]; end
            default: w = {2'b00, a[2:1]};
        endcase
        return {w[2:0], (a > b), (a < b), (a == b), (w[2:0] == 3'd0), c};
    endfunction

    assign {alu_result, alu_greater_than, alu_less_than, alu_equal, alu_zero, alu_carry_out} =
        alu_model(alu_a, alu_b, alu_sel);

    assign o_vld[0] = rsp0_valid;
    assign o_vld[1] = rsp1_valid;
    assign o_res[0] = rsp0_result;
    assign o_res[1] = rsp1_result;
    assign o_flg[0] = rsp0_flags;
    assign o_flg[1] = rsp1_flags;
    assign all_outs = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_result, rsp1_result,
                       rsp0_flags, rsp1_flags, alu_a, alu_b, alu_sel};

    alu_3bit_arbiter #(.RR_INIT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(vld[0]), .req0_ready(req0_ready), .req0_a(pa[0]), .req0_b(pb[0]), .req0_op(po[0]),
        .req1_valid(vld[1]), .req1_ready(req1_ready), .req1_a(pa[1]), .req1_b(pb[1]), .req1_op(po[1]),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rrdy[0]), .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rrdy[1]), .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
        .alu_carry_out(alu_carry_out), .alu_zero(alu_zero), .alu_equal(alu_equal),
        .alu_less_than(alu_less_than), .alu_greater_than(alu_greater_than)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_ptr    = 1'b0;
        last_a     = 3'd0;
        last_b     = 3'd0;
        last_sel   = 3'd0;
        exp_res[0] = 3'd0;
        exp_res[1] = 3'd0;
        exp_flg[0] = 5'd0;
        exp_flg[1] = 5'd0;
    endtask

    task automatic apply_reset();
        vld[0] = 1'b0; vld[1] = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        model_reset();
    endtask

    // Record an accepted request in the reference model
    task automatic model_accept(input logic g);
        last_a   = pa[g];
        last_b   = pb[g];
        last_sel = po[g];
    endtask

    task automatic model_capture(input logic g);
        logic [7:0] e;
        e = alu_model(last_a, last_b, last_sel);
        exp_res[g] = e[7:5];
        exp_flg[g] = e[4:0];
    endtask

    task automatic test_reset();
        vld[0] = 1'b0; vld[1] = 1'b0; rrdy[0] = 1'b1; rrdy[1] = 1'b1;
        pa[0] = 3'd0; pb[0] = 3'd0; po[0] = 3'd0; pa[1] = 3'd0; pb[1] = 3'd0; po[1] = 3'd0;
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (all_outs !== 29'd0) begin n_fail++; $display("FAIL reset_outs: got %h expected 0", all_outs); end
        tick(); tick();
        rst_n = 1'b1;
        model_reset();
        // Abandon a transaction in EXEC
        pa[0] = 3'd5; pb[0] = 3'd3; po[0] = 3'($urandom_range(0, 7));
        vld[0] = 1'b1;
        tick();
        vld[0] = 1'b0;
        n_chk++;
        if (alu_a !== 3'd5) begin n_fail++; $display("FAIL exec_alu_a: got %0d expected 5", alu_a); end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (all_outs !== 29'd0) begin n_fail++; $display("FAIL midexec_reset_outs: got %h expected 0", all_outs); end
        tick();
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL no_rsp_after_reset: got %0b expected 0", rsp0_valid); end
            tick();
        end
        vld[0] = 1'b1; vld[1] = 1'b1;
        #1;
        n_chk++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            n_fail++; $display("FAIL grant_after_reset: got %b expected 01", {req1_ready, req0_ready});
        end
        vld[0] = 1'b0; vld[1] = 1'b0;
        tick();
    endtask

    task automatic test_single();
        pa[0] = 3'd5; pb[0] = 3'd3; po[0] = 3'($urandom_range(0, 7));
        rrdy[0] = 1'b1;
        vld[0] = 1'b1;
        #1;
        n_chk++;
        if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %0b expected 1", req0_ready); end
        tick();
        model_accept(1'b0);
        vld[0] = 1'b0;
        n_chk++;
        if (rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %0b expected 0", rsp0_valid); end
        tick();
        model_capture(1'b0);
        n_chk++;
        if (rsp0_valid !== 1'b1 || rsp0_result !== exp_res[0] || rsp0_flags !== exp_flg[0]) begin
            n_fail++;
            $display("FAIL single_rsp: got v=%0b r=%0d f=%b expected v=1 r=%0d f=%b",
                     rsp0_valid, rsp0_result, rsp0_flags, exp_res[0], exp_flg[0]);
        end
        n_chk++;
        if (rsp0_flags[4:2] !== 3'b100) begin n_fail++; $display("FAIL single_gt: got %b expected 100", rsp0_flags[4:2]); end
        tick();
        exp_ptr = 1'b1;
        n_chk++;
        if (rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL single_clear: got %0b expected 0", rsp0_valid); end
    endtask

    task automatic test_contention();
        logic g;
        logic og;
        apply_reset();
        rrdy[0] = 1'b1; rrdy[1] = 1'b1;
        for (int r = 0; r < 2; r++) begin
            pa[r] = 3'($urandom_range(0, 7)); pb[r] = 3'($urandom_range(0, 7)); po[r] = 3'($urandom_range(0, 7));
        end
        vld[0] = 1'b1; vld[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            g = exp_ptr;
            og = req1_ready;
            n_chk++;
            if (og !== i[0] || (req0_ready ^ req1_ready) !== 1'b1) begin
                n_fail++; $display("FAIL contention_grant%0d: got %b expected grant %0d", i, {req1_ready, req0_ready}, i[0]);
            end
            tick();
            model_accept(g);
            pa[g] = 3'($urandom_range(0, 7)); pb[g] = 3'($urandom_range(0, 7)); po[g] = 3'($urandom_range(0, 7));
            tick();
            model_capture(g);
            n_chk++;
            if (o_vld[g] !== 1'b1 || o_res[g] !== exp_res[g] || o_flg[g] !== exp_flg[g]) begin
                n_fail++;
                $display("FAIL contention_rsp%0d: got v=%0b r=%0d f=%b expected v=1 r=%0d f=%b",
                         i, o_vld[g], o_res[g], o_flg[g], exp_res[g], exp_flg[g]);
            end
            n_chk++;
            if (o_vld[~g] !== 1'b0 || o_res[~g] !== exp_res[~g] || o_flg[~g] !== exp_flg[~g]) begin
                n_fail++;
                $display("FAIL contention_other%0d: got v=%0b r=%0d f=%b expected v=0 r=%0d f=%b",
                         i, o_vld[~g], o_res[~g], o_flg[~g], exp_res[~g], exp_flg[~g]);
            end
            tick();
            exp_ptr = ~g;
        end
        vld[0] = 1'b0; vld[1] = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        pa[1] = 3'd2; pb[1] = 3'd2; po[1] = 3'($urandom_range(0, 7));
        rrdy[1] = 1'b0;
        vld[1] = 1'b1;
        #1;
        n_chk++;
        if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept: got %0b expected 1", req1_ready); end
        tick();
        model_accept(1'b1);
        vld[1] = 1'b0;
        tick();
        model_capture(1'b1);
        pa[0] = 3'($urandom_range(0, 7)); pb[0] = 3'($urandom_range(0, 7)); po[0] = 3'($urandom_range(0, 7));
        vld[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            n_chk++;
            if (rsp1_valid !== 1'b1 || rsp1_result !== exp_res[1] || rsp1_flags !== exp_flg[1] ||
                rsp1_flags[2] !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v=%0b r=%0d f=%b rdy=%b expected v=1 r=%0d f=%b rdy=00",
                         k, rsp1_valid, rsp1_result, rsp1_flags, {req1_ready, req0_ready}, exp_res[1], exp_flg[1]);
            end
            tick();
        end
        rrdy[1] = 1'b1;
        tick();
        exp_ptr = 1'b0;
        n_chk++;
        if (rsp1_valid !== 1'b0 || req0_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: got v=%0b rdy0=%0b expected v=0 rdy0=1", rsp1_valid, req0_ready);
        end
        vld[0] = 1'b0;
        tick();
    endtask

    task automatic test_isolation();
        pa[0] = 3'd7; pb[0] = 3'd0; po[0] = 3'($urandom_range(0, 7));
        rrdy[0] = 1'b1;
        vld[0] = 1'b1;
        tick();
        model_accept(1'b0);
        vld[0] = 1'b0;
        pa[0] = 3'd1;
        n_chk++;
        if (alu_a !== 3'd7 || alu_b !== 3'd0 || alu_sel !== last_sel) begin
            n_fail++; $display("FAIL iso_exec: got a=%0d b=%0d s=%0d expected a=7 b=0 s=%0d", alu_a, alu_b, alu_sel, last_sel);
        end
        tick();
        model_capture(1'b0);
        n_chk++;
        if (rsp0_result !== exp_res[0] || rsp0_flags !== exp_flg[0]) begin
            n_fail++; $display("FAIL iso_rsp: got r=%0d f=%b expected r=%0d f=%b", rsp0_result, rsp0_flags, exp_res[0], exp_flg[0]);
        end
        tick();
        exp_ptr = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (alu_a !== 3'd7 || alu_b !== 3'd0 || alu_sel !== last_sel) begin
                n_fail++; $display("FAIL iso_idle%0d: got a=%0d b=%0d s=%0d expected a=7 b=0 s=%0d", k, alu_a, alu_b, alu_sel, last_sel);
            end
            tick();
        end
    endtask

    task automatic test_idle();
        vld[0] = 1'b0; vld[1] = 1'b0;
        rrdy[0] = 1'b1; rrdy[1] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            n_chk++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 ||
                alu_a !== last_a || alu_b !== last_b || alu_sel !== last_sel ||
                rsp0_result !== exp_res[0] || rsp1_result !== exp_res[1] ||
                rsp0_flags !== exp_flg[0] || rsp1_flags !== exp_flg[1]) begin
                n_fail++; $display("FAIL idle%0d: got outs=%h alu=%0d,%0d,%0d expected alu=%0d,%0d,%0d",
                                   k, all_outs, alu_a, alu_b, alu_sel, last_a, last_b, last_sel);
            end
            tick();
        end
        vld[0] = 1'b1; vld[1] = 1'b1;
        #1;
        n_chk++;
        if (req1_ready !== exp_ptr || req0_ready !== ~exp_ptr) begin
            n_fail++; $display("FAIL idle_ptr: got %b expected grant %0d", {req1_ready, req0_ready}, exp_ptr);
        end
        vld[0] = 1'b0; vld[1] = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int   v;
        int   stall;
        logic g;
        for (int i = 0; i < 16; i++) begin
            rrdy[0] = 1'b0; rrdy[1] = 1'b0;
            v = $urandom_range(0, 3);
            for (int r = 0; r < 2; r++) begin
                pa[r] = 3'($urandom_range(0, 7)); pb[r] = 3'($urandom_range(0, 7)); po[r] = 3'($urandom_range(0, 7));
            end
            vld[0] = (v == 1 || v == 3); vld[1] = (v >= 2);
            #1;
            if (v == 0) begin
                n_chk++;
                if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                    n_fail++; $display("FAIL rnd_noreq%0d: got %b expected 00", i, {req1_ready, req0_ready});
                end
                tick();
            end else begin
                g = (v == 3) ? exp_ptr : (v == 2);
                n_chk++;
                if (req1_ready !== g || req0_ready !== ~g) begin
                    n_fail++; $display("FAIL rnd_grant%0d: got %b expected grant %0d", i, {req1_ready, req0_ready}, g);
                end
                tick();
                model_accept(g);
                vld[0] = 1'b0; vld[1] = 1'b0;
                tick();
                model_capture(g);
                stall = $urandom_range(0, 2);
                for (int s = 0; s <= stall; s++) begin
                    n_chk++;
                    if (o_vld[g] !== 1'b1 || o_res[g] !== exp_res[g] || o_flg[g] !== exp_flg[g] ||
                        o_vld[~g] !== 1'b0 || o_res[~g] !== exp_res[~g] || o_flg[~g] !== exp_flg[~g]) begin
                        n_fail++;
                        $display("FAIL rnd_rsp%0d: got v=%0b%0b r=%0d f=%b expected owner %0d r=%0d f=%b",
                                 i, o_vld[1], o_vld[0], o_res[g], o_flg[g], g, exp_res[g], exp_flg[g]);
                    end
                    if (s == stall) rrdy[g] = 1'b1;
                    tick();
                end
                exp_ptr = ~g;
                n_chk++;
                if (o_vld[g] !== 1'b0) begin n_fail++; $display("FAIL rnd_clear%0d: got %0b expected 0", i, o_vld[g]); end
            end
        end
        rrdy[0] = 1'b0; rrdy[1] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_isolation();
        test_idle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
